// File: rtl/tx_frame_sched_if.sv
// tx_frame_sched_if
// Payload handshake between the TX packet source and tx_frame_sched.
//   data_in        payload word (DATA_W bits), source -> scheduler
//   data_valid_in  payload valid, source -> scheduler
//   data_ready_out scheduler can accept a word, scheduler -> source
// Modports: master = packet source, slave = tx_frame_sched.
interface tx_frame_sched_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid_in;
  logic              data_ready_out;

  modport master (
    output data_in,
    output data_valid_in,
    input  data_ready_out
  );

  modport slave (
    input  data_in,
    input  data_valid_in,
    output data_ready_out
  );
endinterface

// File: rtl/tx_frame_sched.sv
// tx_frame_sched
// Serialises one transmit frame onto the TX line: a fixed preamble, the
// payload MSB-first, an optional even-parity bit, then an enforced idle gap.
// Every bit lasts CLK_DIV system-clock cycles; a 50%-duty bit clock is
// exported for downstream logic.
//
// Ports:
//   clk_in       system clock (50 MHz)
//   rst_n_in     asynchronous active-low reset, synchronous release
//   hs           payload handshake (tx_frame_sched_if.slave)
//   tx_bit_out   serial bit to the modulator
//   tx_en_out    high while preamble/data/parity bits are driven
//   bit_clk_out  bit clock, rising at every bit start, 0 in IDLE
//   done_out     one-cycle pulse on the tick ending the last frame bit
//
// Build option: define TX_FRAME_PARITY_EN to append an even-parity bit
// (XOR of the payload) after the data bits.
module tx_frame_sched #(
  parameter int               CLK_DIV  = 12500,
  parameter int               DATA_W   = 8,
  parameter int               PRE_W    = 8,
  parameter logic [PRE_W-1:0] PREAMBLE = 8'hAA,
  parameter int               GAP_BITS = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  tx_frame_sched_if.slave    hs,
  output logic               tx_bit_out,
  output logic               tx_en_out,
  output logic               bit_clk_out,
  output logic               done_out
);

  localparam int FW   = PRE_W + DATA_W;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int MAXA = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAXN = (MAXA > GAP_BITS) ? MAXA : GAP_BITS;
  localparam int BW   = $clog2(MAXN + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [BW-1:0] PRE_LAST  = BW'(PRE_W - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd4;
  // With GAP_BITS == 0 the frame returns straight to IDLE.
  localparam logic [2:0] S_AFTER = (GAP_BITS > 0) ? S_GAP : S_IDLE;
`ifdef TX_FRAME_PARITY_EN
  localparam logic [2:0] S_PAR       = 3'd3;
  localparam logic [2:0] S_DATA_NEXT = S_PAR;
`else
  localparam logic [2:0] S_DATA_NEXT = S_AFTER;
`endif

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] idx;
  logic [FW-1:0] sh;
  logic          take;
  logic          tick;
  logic          last_bit;
`ifdef TX_FRAME_PARITY_EN
  logic          par;
`endif

  assign take = hs.data_valid_in && (state == S_IDLE);
  assign tick = (state != S_IDLE) && (cnt == CNT_LAST);

  // Control: state, bit-period divider and bit index
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else if (state == S_IDLE) begin
      cnt <= '0;
      idx <= '0;
      if (take) state <= S_PRE;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= idx + BW'(1);
        case (state)
          S_PRE: if (idx == PRE_LAST) begin
            idx   <= '0;
            state <= S_DATA;
          end
          S_DATA: if (idx == DATA_LAST) begin
            idx   <= '0;
            state <= S_DATA_NEXT;
          end
`ifdef TX_FRAME_PARITY_EN
          S_PAR: begin
            idx   <= '0;
            state <= S_AFTER;
          end
`endif
          S_GAP: if (idx == GAP_LAST) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Datapath: preamble and payload share one shift register, MSB leaves first
  always_ff @(posedge clk_in) begin
    if (take) begin
      sh <= {PREAMBLE, hs.data_in};
    end else if (tick && (state == S_PRE || state == S_DATA)) begin
      sh <= {sh[FW-2:0], 1'b0};
    end
  end

`ifdef TX_FRAME_PARITY_EN
  always_ff @(posedge clk_in) begin
    if (take) par <= ^hs.data_in;
  end
  assign last_bit = (state == S_PAR);
`else
  assign last_bit = (state == S_DATA) && (idx == DATA_LAST);
`endif

  // Outputs decode from state so an asynchronous reset clears them at once
  always_comb begin
    tx_bit_out = 1'b0;
    tx_en_out  = 1'b0;
    case (state)
      S_PRE, S_DATA: begin
        tx_bit_out = sh[FW-1];
        tx_en_out  = 1'b1;
      end
`ifdef TX_FRAME_PARITY_EN
      S_PAR: begin
        tx_bit_out = par;
        tx_en_out  = 1'b1;
      end
`endif
      default: begin
        tx_bit_out = 1'b0;
        tx_en_out  = 1'b0;
      end
    endcase
  end

  assign bit_clk_out       = (state != S_IDLE) && (cnt < CNT_HALF);
  assign done_out          = tick && last_bit;
  assign hs.data_ready_out = (state == S_IDLE);

endmodule

// File: tb/tb_tx_frame_sched.sv
module tb_tx_frame_sched;

`ifdef TX_FRAME_PARITY_EN
  localparam int FB = 17;
`else
  localparam int FB = 16;
`endif
  localparam int CD  = 4;
  localparam int GB  = 4;
  localparam int TOT = (FB + GB) * CD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_bit, tx_en, bclk, done;
  int   checks = 0;
  int   errors = 0;

  tx_frame_sched_if #(.DATA_W(8)) hs ();

  tx_frame_sched #(
    .CLK_DIV (CD),
    .DATA_W  (8),
    .PRE_W   (8),
    .PREAMBLE(8'hAA),
    .GAP_BITS(GB)
  ) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .hs         (hs),
    .tx_bit_out (tx_bit),
    .tx_en_out  (tx_en),
    .bit_clk_out(bclk),
    .done_out   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at cycle 0 (IDLE, ready high); transfer happens on the next edge.
  task automatic xfer(input logic [7:0] d);
    hs.data_in       = d;
    hs.data_valid_in = 1'b1;
    step();
    hs.data_valid_in = 1'b0;
  endtask

  // Entered at cycle 1 of a frame. pat holds the frame bits, first bit at
  // pat[16]. Optionally pulses data_valid_in with 8'hFF at cycle inj.
  task automatic frame_check(input string nm, input logic [16:0] pat, input int inj);
    int dones = 0;
    for (int k = 1; k <= TOT; k++) begin
      logic eb;
      eb = (k <= FB * CD) ? pat[16 - (k - 1) / CD] : 1'b0;
      chk($sformatf("%s_bit_c%0d", nm, k), tx_bit, eb);
      chk($sformatf("%s_en_c%0d", nm, k), tx_en, (k <= FB * CD));
      chk($sformatf("%s_bclk_c%0d", nm, k), bclk, (((k - 1) % CD) < CD / 2));
      chk($sformatf("%s_rdy_c%0d", nm, k), hs.data_ready_out, 1'b0);
      chk($sformatf("%s_done_c%0d", nm, k), done, (k == FB * CD));
      if (done) dones++;
      if (inj > 0 && k == inj) begin
        hs.data_in       = 8'hFF;
        hs.data_valid_in = 1'b1;
      end
      if (inj > 0 && k == inj + 1) hs.data_valid_in = 1'b0;
      step();
    end
    chk($sformatf("%s_rdy_end", nm), hs.data_ready_out, 1'b1);
    chk($sformatf("%s_bclk_end", nm), bclk, 1'b0);
    chk($sformatf("%s_en_end", nm), tx_en, 1'b0);
    chk($sformatf("%s_done_count", nm), dones, 1);
  endtask

  initial begin
    logic [16:0] p5a, p00, p3c, p81;
`ifdef TX_FRAME_PARITY_EN
    logic [16:0] p07;
    p5a = 17'b1010_1010_0101_1010_0;
    p00 = 17'b1010_1010_0000_0000_0;
    p3c = 17'b1010_1010_0011_1100_0;
    p81 = 17'b1010_1010_1000_0001_0;
    p07 = 17'b1010_1010_0000_0111_1;
`else
    p5a = 17'b1010_1010_0101_1010_0;
    p00 = 17'b1010_1010_0000_0000_0;
    p3c = 17'b1010_1010_0011_1100_0;
    p81 = 17'b1010_1010_1000_0001_0;
`endif
    hs.data_in       = 8'h00;
    hs.data_valid_in = 1'b0;

    // Reset state
    #12;
    chk("rst_rdy", hs.data_ready_out, 1'b1);
    chk("rst_bit", tx_bit, 1'b0);
    chk("rst_en", tx_en, 1'b0);
    chk("rst_bclk", bclk, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: basic frame 8'h5A
    xfer(8'h5A);
    frame_check("f5a", p5a, 0);

    // 2: valid pulse with 8'hFF during frame 8'h00 is ignored
    xfer(8'h00);
    frame_check("f00", p00, 10);

    // 3: valid held high -> back-to-back transfers 81 cycles apart
    hs.data_in       = 8'h3C;
    hs.data_valid_in = 1'b1;
    step();
    frame_check("f3c_a", p3c, 0);
    step();
    hs.data_valid_in = 1'b0;
    frame_check("f3c_b", p3c, 0);

    // 5: bit clock stays low while idle
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("idle_bclk_%0d", i), bclk, 1'b0);
      chk($sformatf("idle_en_%0d", i), tx_en, 1'b0);
      step();
    end

    // 4: asynchronous reset at cycle 30 of a frame
    xfer(8'hC3);
    for (int k = 1; k < 30; k++) step();
    chk("mid_en_before", tx_en, 1'b1);
    chk("mid_bclk_before", bclk, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", hs.data_ready_out, 1'b1);
    chk("arst_bit", tx_bit, 1'b0);
    chk("arst_en", tx_en, 1'b0);
    chk("arst_bclk", bclk, 1'b0);
    chk("arst_done", done, 1'b0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk($sformatf("post_rst_done_%0d", i), done, 1'b0);
      chk($sformatf("post_rst_en_%0d", i), tx_en, 1'b0);
    end
    xfer(8'h81);
    frame_check("f81", p81, 0);

`ifdef TX_FRAME_PARITY_EN
    // 6: parity bit, three ones -> 1, four ones -> 0
    xfer(8'h07);
    for (int k = 1; k < 65; k++) step();
    chk("par07_bit", tx_bit, 1'b1);
    chk("par07_en", tx_en, 1'b1);
    for (int k = 65; k < 68; k++) step();
    chk("par07_done", done, 1'b1);
    step();
    chk("par07_en_off", tx_en, 1'b0);
    for (int k = 69; k <= TOT; k++) step();
    step();
    xfer(8'h07);
    frame_check("f07", p07, 0);
    xfer(8'h5A);
    for (int k = 1; k < 65; k++) step();
    chk("par5a_bit", tx_bit, 1'b0);
    chk("par5a_en", tx_en, 1'b1);
    for (int k = 65; k <= TOT; k++) step();
    chk("par5a_rdy", hs.data_ready_out, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
Sequences one transmit frame onto the single-bit TX line at the binary-code symbol rate.
- Accepts a data word over a valid/ready handshake.
- Derives the bit period internally from the 50 MHz system clock.
- Shifts out a fixed preamble, then the data MSB-first, then an enforced idle gap.
- Sits between the TX packet source and the modulator/line driver. Also outputs a bit-rate clock, 4 kHz at default parameters, for downstream logic.

Parameters:
CLK_DIV, 12500, system-clock cycles per bit (50 MHz / 4 kHz); must be even and >= 4
DATA_W, 8, payload bits per frame
PRE_W, 8, preamble length in bits
PREAMBLE, 8'hAA, preamble pattern, sent MSB-first
GAP_BITS, 4, idle bit periods enforced after each frame; 0 allowed

Ports:
clk_in  input  1  system clock, 50 MHz
rst_n_in  input  1  asynchronous active-low reset
data_in  input  DATA_W  payload word
data_valid_in  input  1  payload valid
data_ready_out  output  1  block can accept a word
tx_bit_out  output  1  serial bit to modulator
tx_en_out  output  1  high while preamble/data/parity bits are driven
bit_clk_out  output  1  50%-duty bit clock, rising at each bit start
done_out  output  1  one-cycle pulse at end of last frame bit

Behaviour:
- Reset (async assert, sync release): state IDLE, data_ready_out=1, tx_bit_out=0, tx_en_out=0, bit_clk_out=0, done_out=0, divider counter=0. Reset mid-frame abandons the frame immediately; no done_out is produced.
- Divider: counter runs 0..CLK_DIV-1 only outside IDLE. A bit tick occurs on the cycle counter==CLK_DIV-1; counter wraps to 0 on that cycle.
- bit_clk_out = 1 when counter < CLK_DIV/2 and state != IDLE, else 0.
- Handshake: transfer occurs on a clock edge with data_valid_in & data_ready_out. data_ready_out is 1 only in IDLE. data_valid_in is ignored in all other states; held data is not queued.
- States:
  - IDLE: on transfer, latch data_in into a shift register, counter=0, go to PRE. Next cycle: tx_en_out=1, tx_bit_out=PREAMBLE[PRE_W-1], data_ready_out=0.
  - PRE: each bit is held CLK_DIV cycles. Bit index advances on tick. After PRE_W ticks, go to DATA.
  - DATA: drives data MSB-first, DATA_W bits, each CLK_DIV cycles. After the last tick, go to PAR if PARITY_EN is defined, else to GAP.
  - PAR: see Optional Feature.
  - GAP: tx_en_out=0, tx_bit_out=0, bit_clk_out keeps running. After GAP_BITS ticks, go to IDLE; data_ready_out=1 on the next cycle. If GAP_BITS=0, go directly from the last frame bit to IDLE.
- done_out: asserted for exactly one cycle, on the tick that ends the final frame bit (last data bit or parity bit).
- Latency: the first preamble bit appears 1 cycle after the transfer edge.
- Frame duration with tx_en_out=1: (PRE_W+DATA_W[+1])*CLK_DIV cycles.
- Back-to-back: minimum transfer-to-transfer spacing = (frame bits + GAP_BITS)*CLK_DIV + 1 cycles.
- Bit-index counters are sized with $clog2 of the largest count plus 1. No overflow is possible for legal parameters.

Optional Feature:
Macro TX_FRAME_PARITY_EN.
- Defined: a PAR state follows DATA. It drives one even-parity bit (XOR of the latched payload) for CLK_DIV cycles with tx_en_out=1, and done_out pulses at its end.
- Undefined: the PAR state and parity logic are absent. DATA goes straight to GAP/IDLE, and the frame is PRE_W+DATA_W bits.

Test Plan (CLK_DIV=4, GAP_BITS=4, defaults otherwise):
1. Reset, then transfer 8'h5A -> tx_bit_out sequence 1010_1010_0101_1010 over 64 cycles, each bit held 4 cycles; tx_en_out high 64 cycles; done_out pulses once at cycle 64; data_ready_out high at cycle 81.
2. Pulse data_valid_in with 8'hFF during frame 8'h00 -> ignored; data_ready_out stays 0; serialized payload is 0000_0000.
3. Hold data_valid_in high continuously with 8'h3C -> second transfer lands exactly 81 cycles after the first; gap shows tx_en_out=0 for 16 cycles.
4. Assert rst_n_in low at cycle 30 of a frame -> all outputs at reset values in the same cycle without waiting for a clock edge; no done_out; after release, a new transfer of 8'h81 serializes correctly.
5. bit_clk_out check -> period 4 cycles, high 2/low 2, rising aligned with every tx_bit_out change; constant 0 in IDLE.
6. TX_FRAME_PARITY_EN defined, transfer 8'h07 -> 17 bits, final bit 1 (three ones), tx_en_out high 68 cycles, done_out pulses at cycle 68; with 8'h5A the final bit is 0.
